// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: turns DR/IR scan and TAP-reset commands into JTAG pin sequences
// and returns the captured TDO bits as a response.
module jtag_scan_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        jtag_TCK,
    output logic        jtag_TMS,
    output logic        jtag_TDI,
    output logic        jtag_TRSTn,
    input  logic        jtag_TDO
);
    typedef enum logic [2:0] {INIT, IDLE, HEAD, SHIFT, TAIL, RESP} state_t;

    localparam logic [8:0] HALF    = 9'(CLK_DIV);
    localparam logic [8:0] PER_END = 9'(2 * CLK_DIV - 1);

    state_t      state, state_n;
    logic [8:0]  div, div_n;
    logic [5:0]  cnt, cnt_n, len, len_n;
    logic        ir, ir_n;
    logic [31:0] data, data_n, cap;
    logic        last, end_p, tck_n, tms_n, tdi_n;

    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_data  = cap;
    assign busy      = state != IDLE;
    assign end_p     = div == PER_END;

    always_comb begin
        state_n = state;
        div_n   = div;
        cnt_n   = cnt;
        ir_n    = ir;
        len_n   = len;
        data_n  = data;
        last    = state == INIT  ? cnt == 6'd5 :
                  state == HEAD  ? cnt == (ir ? 6'd3 : 6'd2) :
                  state == SHIFT ? cnt == len - 6'd1 :
                  state == TAIL  ? cnt == 6'd1 : 1'b0;
        // The first clock after reset only releases TRSTn; INIT periods start after it.
        if (!jtag_TRSTn) begin
            state_n = INIT;
        end else if (state == IDLE) begin
            if (cmd_valid) begin
                state_n = cmd_op[1] ? INIT : HEAD;
                ir_n    = cmd_op == 2'd1;
                len_n   = cmd_len == 6'd0 ? 6'd1 : cmd_len > 6'd32 ? 6'd32 : cmd_len;
                data_n  = cmd_data;
                div_n   = '0;
                cnt_n   = '0;
            end
        end else if (state == RESP) begin
            if (rsp_ready) state_n = IDLE;
        end else begin
            div_n = end_p ? 9'd0 : div + 9'd1;
            if (end_p) begin
                cnt_n = last ? 6'd0 : cnt + 6'd1;
                if (last)
                    state_n = state == INIT ? IDLE : state == HEAD ? SHIFT :
                              state == SHIFT ? TAIL : RESP;
            end
        end
        tms_n = state_n == INIT  ? cnt_n < 6'd5 :
                state_n == HEAD  ? (ir_n ? cnt_n < 6'd2 : cnt_n == 6'd0) :
                state_n == SHIFT ? cnt_n == len_n - 6'd1 :
                state_n == TAIL  ? cnt_n == 6'd0 : 1'b0;
        tdi_n = state_n == SHIFT && data_n[cnt_n[4:0]];
        tck_n = (state_n inside {INIT, HEAD, SHIFT, TAIL}) && div_n >= HALF;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            div        <= '0;
            cnt        <= '0;
            len        <= '0;
            ir         <= 1'b0;
            data       <= '0;
            cap        <= '0;
            jtag_TCK   <= 1'b0;
            jtag_TMS   <= 1'b1;
            jtag_TDI   <= 1'b0;
            jtag_TRSTn <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            cnt        <= cnt_n;
            len        <= len_n;
            ir         <= ir_n;
            data       <= data_n;
            jtag_TCK   <= jtag_TRSTn && tck_n;
            jtag_TMS   <= tms_n;
            jtag_TDI   <= jtag_TRSTn && tdi_n;
            jtag_TRSTn <= 1'b1;
            // Capture on the edge where TCK rises, i.e. the last low clock of a SHIFT period.
            if (state == IDLE && cmd_valid)
                cap <= '0;
            else if (state == SHIFT && div == HALF - 9'd1)
                cap[cnt[4:0]] <= jtag_TDO;
        end
    end
endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// tb_jtag_scan_ctrl: directed bench with a behavioural TAP (1-bit bypass DR,
// 5-bit IR capturing 00001) attached to the JTAG pins.
module tb_jtag_scan_ctrl;
    logic        clock = 0, reset = 1;
    logic        cmd_valid = 0, rsp_ready = 0;
    logic [1:0]  cmd_op = 0;
    logic [5:0]  cmd_len = 0;
    logic [31:0] cmd_data = 0;
    logic        cmd_ready, rsp_valid, busy;
    logic [31:0] rsp_data;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        tdo = 0;

    int tests = 0, fails = 0;
    int ntck = 0, nrsp = 0;
    logic [63:0] tms_h = 0, tdi_h = 0;

    jtag_scan_ctrl #(.CLK_DIV(2)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
        .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn), .jtag_TDO(tdo)
    );

    always #5 clock = ~clock;

    typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHD, E1D, PDR, E2D, UPD,
                              SIR, CIR, SHI, E1I, PIR, E2I, UPI} tap_t;
    tap_t       tap = TLR;
    logic       byp = 0;
    logic [4:0] irsr = 0, tap_ir = 0;

    function automatic tap_t nxt(input tap_t s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDR : RTI;
            SDR: return m ? SIR : CDR;
            CDR: return m ? E1D : SHD;
            SHD: return m ? E1D : SHD;
            E1D: return m ? UPD : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UPD : SHD;
            UPD: return m ? SDR : RTI;
            SIR: return m ? TLR : CIR;
            CIR: return m ? E1I : SHI;
            SHI: return m ? E1I : SHI;
            E1I: return m ? UPI : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UPI : SHI;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge jtag_TCK or negedge jtag_TRSTn) begin
        if (!jtag_TRSTn) begin
            tap <= TLR;
        end else begin
            if (tap == CDR) byp <= 1'b0;
            if (tap == SHD) byp <= jtag_TDI;
            if (tap == CIR) irsr <= 5'b00001;
            if (tap == SHI) irsr <= {jtag_TDI, irsr[4:1]};
            if (tap == UPI) tap_ir <= irsr;
            tap <= nxt(tap, jtag_TMS);
        end
    end

    always @(negedge jtag_TCK) tdo <= tap == SHD ? byp : tap == SHI ? irsr[0] : 1'b0;

    always @(posedge jtag_TCK) begin
        ntck  <= ntck + 1;
        tms_h <= {tms_h[62:0], jtag_TMS};
        tdi_h <= {tdi_h[62:0], jtag_TDI};
    end

    always @(posedge clock) if (rsp_valid) nrsp <= nrsp + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d);
        @(negedge clock);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_len = len; cmd_data = d;
        @(posedge clock); #1;
        cmd_valid = 0; cmd_op = 2'd2; cmd_len = 6'd3; cmd_data = ~d;
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 2000) begin @(posedge clock); #1; k++; end
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!cmd_ready && k < 2000) begin @(posedge clock); #1; k++; end
    endtask

    task automatic ack;
        @(negedge clock); rsp_ready = 1;
        @(posedge clock); #1; rsp_ready = 0;
        check("ack_clears", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int k, t0, r0;
        logic ok;
        logic [31:0] held;
        repeat (3) @(negedge clock);
        check("reset_pins", {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, cmd_ready, rsp_valid, busy}, 7'b0100001);
        check("reset_rsp_data", rsp_data, 0);

        // Reset release: TRSTn on the first edge, then 6 INIT periods.
        t0 = ntck;
        reset = 0;
        @(posedge clock); #1;
        check("trstn_release", jtag_TRSTn, 1);
        wait_ready(k);
        check("init_clocks", k, 24);
        check("init_tck", ntck - t0, 6);
        check("init_tms", tms_h[5:0], 6'b111110);
        check("init_tap_rti", tap, RTI);

        // DR scan, 8 bits of 0xA5 through the bypass register.
        t0 = ntck;
        send(2'd0, 6'd8, 32'hA5);
        wait_rsp(k);
        check("dr_clocks", k, 52);
        check("dr_tck", ntck - t0, 13);
        check("dr_tms", tms_h[12:0], 13'h1006);
        check("dr_tdi", tdi_h[12:0], 13'h0294);
        check("dr_rsp", rsp_data, 32'h4A);
        check("resp_pins", {busy, cmd_ready, jtag_TCK, jtag_TMS}, 4'b1000);
        ack();

        // IR scan, 5 bits of 0x11.
        t0 = ntck;
        send(2'd1, 6'd5, 32'h11);
        wait_rsp(k);
        check("ir_clocks", k, 44);
        check("ir_tck", ntck - t0, 11);
        check("ir_rsp", rsp_data, 32'h01);
        check("ir_value", tap_ir, 5'h11);
        check("ir_tap_rti", tap, RTI);
        ack();

        // Backpressure with a second command waiting.
        send(2'd0, 6'd4, 32'h5);
        wait_rsp(k);
        check("bp_rsp", rsp_data, 32'hA);
        @(negedge clock);
        cmd_valid = 1; cmd_op = 2'd0; cmd_len = 6'd2; cmd_data = 32'h3;
        held = rsp_data; t0 = ntck; ok = 1;
        repeat (50) begin
            @(negedge clock);
            if (rsp_data !== held || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) ok = 0;
        end
        check("bp_stable", ok, 1);
        check("bp_no_accept", ntck - t0, 0);
        rsp_ready = 1;
        @(posedge clock); #1;
        check("bp_handshake", {rsp_valid, cmd_ready}, 2'b01);
        @(negedge clock); rsp_ready = 0;
        @(posedge clock); #1;
        cmd_valid = 0;
        check("bp_accept_next", {cmd_ready, busy}, 2'b01);
        wait_rsp(k);
        check("bp2_tck", ntck - t0, 7);
        check("bp2_rsp", rsp_data, 32'h2);
        ack();

        // cmd_len 40 clamps to 32.
        t0 = ntck;
        send(2'd0, 6'd40, 32'hC3A55A3C);
        wait_rsp(k);
        check("len40_tck", ntck - t0, 37);
        check("len40_rsp", rsp_data, 32'h874AB478);
        ack();

        // cmd_len 0 gives one shift period; upper capture bits cleared.
        t0 = ntck;
        send(2'd0, 6'd0, 32'h1);
        wait_rsp(k);
        check("len0_tck", ntck - t0, 6);
        check("len0_tms", tms_h[5:0], 6'b100110);
        check("len0_rsp", rsp_data, 32'h0);
        ack();

        // Reserved op behaves as TAP reset with no response.
        t0 = ntck; r0 = nrsp;
        send(2'd3, 6'd7, 32'hFFFF);
        wait_ready(k);
        check("op3_clocks", k, 24);
        check("op3_tck", ntck - t0, 6);
        check("op3_tms", tms_h[5:0], 6'b111110);
        check("op3_no_rsp", nrsp - r0, 0);

        // Reset in the middle of a 32-bit shift.
        t0 = ntck;
        send(2'd0, 6'd32, 32'hFFFFFFFF);
        k = 0;
        while (ntck - t0 < 13 && k < 2000) begin @(negedge clock); k++; end
        check("mid_tap_shift", tap, SHD);
        reset = 1;
        #1;
        check("mid_reset_pins", {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, cmd_ready, rsp_valid, busy}, 7'b0100001);
        check("mid_reset_rsp_data", rsp_data, 0);
        r0 = nrsp; t0 = ntck;
        repeat (2) @(negedge clock);
        reset = 0;
        @(posedge clock); #1;
        wait_ready(k);
        check("reinit_clocks", k, 24);
        check("reinit_tck", ntck - t0, 6);
        check("reinit_tms", tms_h[5:0], 6'b111110);
        check("reinit_no_rsp", nrsp - r0, 0);
        check("reinit_tap_rti", tap, RTI);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
